// File: rtl/miner_sched_pkg.sv
// Shared types, constants and job record layout for the miner job scheduler.
package miner_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HALT,
        S_REPORT
    } state_e;

    typedef enum logic [1:0] {
        RES_FOUND        = 2'd0,
        RES_EXHAUSTED    = 2'd1,
        RES_ABORTED      = 2'd2,
        RES_HALT_TIMEOUT = 2'd3
    } res_code_e;

    // core_control bit positions
    localparam int unsigned CTL_RUN           = 0;
    localparam int unsigned CTL_TEST          = 1;
    localparam int unsigned CTL_HALT          = 2;
    localparam int unsigned CTL_PAD_LAST_LSB  = 3;
    localparam int unsigned CTL_PAD_FIRST_LSB = 11;
    localparam int unsigned CTL_W             = 19;

    // core_status bit positions
    localparam int unsigned ST_FOUND   = 0;
    localparam int unsigned ST_RUNNING = 1;
    localparam int unsigned ST_TESTING = 2;

    // Packed job record layout, LSB first: header, difficulty, start, pad, test, budget, id
    localparam int unsigned JOB_HDR_LSB   = 0;
    localparam int unsigned JOB_DIFF_LSB  = 256;
    localparam int unsigned JOB_START_LSB = 512;
    localparam int unsigned JOB_PAD_LSB   = 576;
    localparam int unsigned JOB_TEST_BIT  = 592;
    localparam int unsigned JOB_BUD_LSB   = 593;
    localparam int unsigned JOB_ID_LSB    = 625;
    localparam int unsigned JOB_BASE_W    = 256 + 256 + 64 + 16 + 1 + 32;

    function automatic int unsigned job_rec_w(input int unsigned id_w);
        return JOB_BASE_W + id_w;
    endfunction

endpackage

// File: rtl/miner_job_sched_if.sv
// Job submission and result return bus between the register file and the scheduler.
interface miner_job_sched_if #(
    parameter int unsigned ID_W = 8
);
    logic            job_valid;
    logic            job_ready;
    logic [ID_W-1:0] job_id;
    logic [255:0]    job_header;
    logic [255:0]    job_difficulty;
    logic [63:0]     job_start;
    logic [15:0]     job_pad;
    logic            job_test;
    logic [31:0]     job_budget;
    logic            abort;
    logic            res_valid;
    logic            res_ready;
    logic [ID_W-1:0] res_id;
    logic [1:0]      res_code;
    logic [63:0]     res_nonce;
    logic [31:0]     res_cycles;

    modport master (
        output job_valid, job_id, job_header, job_difficulty, job_start,
               job_pad, job_test, job_budget, abort, res_ready,
        input  job_ready, res_valid, res_id, res_code, res_nonce, res_cycles
    );

    modport slave (
        input  job_valid, job_id, job_header, job_difficulty, job_start,
               job_pad, job_test, job_budget, abort, res_ready,
        output job_ready, res_valid, res_id, res_code, res_nonce, res_cycles
    );
endinterface

// File: rtl/miner_job_fifo.sv
// Synchronous FIFO of packed job records; reset flushes pointers and occupancy.
module miner_job_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [W-1:0]            wr_data,
    input  logic                    pop,
    output logic [W-1:0]            rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/miner_job_sched.sv
// Autonomous job sequencer for the sha3_256_miner core: queue, load, run, halt, report.
module miner_job_sched
    import miner_sched_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_W     = 8,
    parameter int unsigned HALT_TMO = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    miner_job_sched_if.slave       bus,
    output logic [255:0]           core_header,
    output logic [255:0]           core_difficulty,
    output logic [63:0]            core_start_nonce,
    output logic [CTL_W-1:0]       core_control,
    input  logic [2:0]             core_status,
    input  logic [63:0]            core_solution,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned REC_W = job_rec_w(ID_W);
    localparam int unsigned TW    = $clog2(HALT_TMO) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(HALT_TMO - 1);

    logic [REC_W-1:0] rec_in, rec_out;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic             found, running, unused_testing;

    state_e           state_q, state_d;
    logic [255:0]     hdr_q, hdr_d, diff_q, diff_d;
    logic [63:0]      start_q, start_d;
    logic [15:0]      pad_q, pad_d;
    logic             test_q, test_d, run_q, run_d, halt_q, halt_d;
    logic [31:0]      budget_q, budget_d, cyc_q, cyc_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             res_valid_q, res_valid_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    res_code_e        res_code_q, res_code_d;
    logic [63:0]      res_nonce_q, res_nonce_d;
    logic [31:0]      res_cycles_q, res_cycles_d;

    assign rec_in = {bus.job_id, bus.job_budget, bus.job_test, bus.job_pad,
                     bus.job_start, bus.job_difficulty, bus.job_header};

    miner_job_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.job_valid),
        .wr_data (rec_in),
        .pop     (fifo_pop),
        .rd_data (rec_out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign found          = core_status[ST_FOUND];
    assign running        = core_status[ST_RUNNING];
    assign unused_testing = core_status[ST_TESTING];

    assign bus.job_ready    = !fifo_full;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_id       = res_id_q;
    assign bus.res_code     = res_code_q;
    assign bus.res_nonce    = res_nonce_q;
    assign bus.res_cycles   = res_cycles_q;
    assign core_header      = hdr_q;
    assign core_difficulty  = diff_q;
    assign core_start_nonce = start_q;
    assign core_control     = {pad_q, halt_q, test_q, run_q};
    assign busy             = (state_q != S_IDLE);

    // Sequencer next-state; control outputs are computed one cycle ahead so they are registered
    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        diff_d       = diff_q;
        start_d      = start_q;
        pad_d        = pad_q;
        test_d       = test_q;
        run_d        = run_q;
        halt_d       = halt_q;
        budget_d     = budget_q;
        cyc_d        = cyc_q;
        tmo_d        = tmo_q;
        res_valid_d  = res_valid_q;
        res_id_d     = res_id_q;
        res_code_d   = res_code_q;
        res_nonce_d  = res_nonce_q;
        res_cycles_d = res_cycles_q;
        fifo_pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hdr_d    = rec_out[JOB_HDR_LSB   +: 256];
                    diff_d   = rec_out[JOB_DIFF_LSB  +: 256];
                    start_d  = rec_out[JOB_START_LSB +: 64];
                    pad_d    = rec_out[JOB_PAD_LSB   +: 16];
                    test_d   = rec_out[JOB_TEST_BIT];
                    budget_d = rec_out[JOB_BUD_LSB   +: 32];
                    res_id_d = rec_out[JOB_ID_LSB    +: ID_W];
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (budget_q == '0) begin
                    res_code_d   = RES_EXHAUSTED;
                    res_cycles_d = '0;
                    res_nonce_d  = '0;
                    res_valid_d  = 1'b1;
                    state_d      = S_REPORT;
                end else begin
                    run_d   = 1'b1;
                    cyc_d   = 32'd1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (found || bus.abort || (cyc_q == budget_q)) begin
                    res_cycles_d = cyc_q;
                    res_nonce_d  = found ? core_solution : '0;
                    res_code_d   = found ? RES_FOUND : (bus.abort ? RES_ABORTED : RES_EXHAUSTED);
                    run_d        = 1'b0;
                    halt_d       = 1'b1;
                    tmo_d        = '0;
                    state_d      = S_HALT;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            S_HALT: begin
                if (!running) begin
                    halt_d      = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = S_REPORT;
                end else if (tmo_q == TMO_LAST) begin
                    halt_d      = 1'b0;
                    res_code_d  = RES_HALT_TIMEOUT;
                    res_nonce_d = '0;
                    res_valid_d = 1'b1;
                    state_d     = S_REPORT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_REPORT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hdr_q        <= '0;
            diff_q       <= '0;
            start_q      <= '0;
            pad_q        <= '0;
            test_q       <= 1'b0;
            run_q        <= 1'b0;
            halt_q       <= 1'b0;
            budget_q     <= '0;
            cyc_q        <= '0;
            tmo_q        <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_code_q   <= RES_FOUND;
            res_nonce_q  <= '0;
            res_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            diff_q       <= diff_d;
            start_q      <= start_d;
            pad_q        <= pad_d;
            test_q       <= test_d;
            run_q        <= run_d;
            halt_q       <= halt_d;
            budget_q     <= budget_d;
            cyc_q        <= cyc_d;
            tmo_q        <= tmo_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_code_q   <= res_code_d;
            res_nonce_q  <= res_nonce_d;
            res_cycles_q <= res_cycles_d;
        end
    end

endmodule

// File: tb/tb_miner_job_sched.sv
// Self-checking bench for miner_job_sched: directed scenarios plus randomized jobs vs. a result model.
module tb_miner_job_sched;
    import miner_sched_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ID_W     = 8;
    localparam int unsigned HALT_TMO = 64;
    localparam int unsigned LW       = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    miner_job_sched_if #(.ID_W(ID_W)) bus ();

    logic [255:0]    core_header, core_difficulty;
    logic [63:0]     core_start_nonce;
    logic [CTL_W-1:0] core_control;
    logic [2:0]      core_status;
    logic [63:0]     core_solution;
    logic            busy;
    logic [LW-1:0]   level;

    miner_job_sched #(.DEPTH(DEPTH), .ID_W(ID_W), .HALT_TMO(HALT_TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .core_header      (core_header),
        .core_difficulty  (core_difficulty),
        .core_start_nonce (core_start_nonce),
        .core_control     (core_control),
        .core_status      (core_status),
        .core_solution    (core_solution),
        .busy             (busy),
        .level            (level)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Core behaviour knobs for the current job
    int          sc_found = 0;
    int          sc_abort = 0;
    bit          sc_stuck = 1'b0;
    logic [63:0] sc_sol   = '0;
    int          rcnt     = 0;
    int          run_cyc  = 0;
    int          halt_cyc = 0;

    // Core model: counts RUN cycles, raises found/abort on the chosen cycle, abort noise outside RUN
    initial begin
        core_status   = '0;
        core_solution = '0;
        bus.abort     = 1'b0;
        forever begin
            @(negedge clk);
            if (core_control[CTL_RUN]) rcnt++;
            else rcnt = 0;
            if (core_control[CTL_RUN]) run_cyc++;
            if (core_control[CTL_HALT]) halt_cyc++;
            core_solution = sc_sol;
            core_status   = {core_control[CTL_TEST],
                             core_control[CTL_RUN] | sc_stuck,
                             core_control[CTL_RUN] && (rcnt == sc_found)};
            bus.abort = core_control[CTL_RUN] ? (rcnt == sc_abort) : ($urandom_range(0, 3) == 0);
        end
    end

    // Expected outcome from the job rules: earliest terminating event, found beats abort beats budget
    function automatic void model(input int bud, input int fa, input int ab, input bit stuck,
                                  output int code, output int cyc, output int halts);
        if (bud == 0) begin
            code = 1; cyc = 0; halts = 0;
        end else begin
            cyc  = bud; code = 1;
            if (ab > 0 && ab <= cyc) begin cyc = ab; code = 2; end
            if (fa > 0 && fa <= cyc) begin cyc = fa; code = 0; end
            halts = stuck ? HALT_TMO : 1;
            if (stuck) code = 3;
        end
    endfunction

    task automatic push_job(input logic [ID_W-1:0] id, input logic [31:0] bud);
        int w;
        logic [255:0] h, d;
        for (int i = 0; i < 8; i++) begin
            h[i*32 +: 32] = $urandom;
            d[i*32 +: 32] = $urandom;
        end
        bus.job_id         = id;
        bus.job_budget     = bud;
        bus.job_header     = h;
        bus.job_difficulty = d;
        bus.job_start      = {$urandom, $urandom};
        bus.job_pad        = 16'($urandom);
        bus.job_test       = 1'($urandom);
        bus.job_valid      = 1'b1;
        w = 0;
        while (!bus.job_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.job_ready) chk("push_wait", bus.job_ready, 1'b1);
        @(negedge clk);
        bus.job_valid = 1'b0;
    endtask

    task automatic ack_result();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("valid_drop", bus.res_valid, 1'b0);
    endtask

    task automatic wait_result(input int lim);
        int w;
        w = 0;
        while (!bus.res_valid && w < lim) begin
            @(negedge clk);
            w++;
        end
        chk("res_valid", bus.res_valid, 1'b1);
    endtask

    task automatic run_job(input logic [ID_W-1:0] id, input int bud, input int fa, input int ab,
                           input bit stuck, input logic [63:0] sol, input int hold);
        int code, cyc, halts, lat, w;
        bit seen;
        sc_found = fa; sc_abort = ab; sc_stuck = stuck; sc_sol = sol;
        run_cyc = 0; halt_cyc = 0;
        model(bud, fa, ab, stuck, code, cyc, halts);
        push_job(id, bud);
        lat = 1; seen = 1'b0; w = 0;
        while (!bus.res_valid && w < bud + HALT_TMO + 20) begin
            if (core_control[CTL_RUN] && !seen) begin
                seen = 1'b1;
                chk("latency", lat, 3);
                chk("core_header", core_header, bus.job_header);
                chk("core_difficulty", core_difficulty, bus.job_difficulty);
                chk("core_start", core_start_nonce, bus.job_start);
                chk("core_pad", core_control[CTL_W-1:CTL_PAD_LAST_LSB], bus.job_pad);
                chk("core_test", core_control[CTL_TEST], bus.job_test);
            end
            @(negedge clk);
            lat++; w++;
        end
        chk("res_valid", bus.res_valid, 1'b1);
        chk("res_id", bus.res_id, id);
        chk("res_code", bus.res_code, code);
        chk("res_nonce", bus.res_nonce, (code == 0) ? sol : 64'd0);
        chk("res_cycles", bus.res_cycles, cyc);
        chk("run_cycles", run_cyc, cyc);
        chk("halt_cycles", halt_cyc, halts);
        chk("core_halt_low", core_control[CTL_HALT], 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.res_valid, 1'b1);
            chk("hold_busy", busy, 1'b1);
            chk("hold_code", bus.res_code, code);
            chk("hold_cycles", bus.res_cycles, cyc);
        end
        ack_result();
        chk("idle_after_ack", busy, 1'b0);
    endtask

    // Safety net against a stalled run
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        bus.job_valid = 1'b0; bus.res_ready = 1'b0;
        bus.job_id = '0; bus.job_budget = '0; bus.job_header = '0; bus.job_difficulty = '0;
        bus.job_start = '0; bus.job_pad = '0; bus.job_test = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_job_ready", bus.job_ready, 1'b1);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_control", core_control, 0);
        chk("rst_header", core_header, 0);
        chk("rst_nonce", bus.res_nonce, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios
        run_job(8'd5, 1000, 17, 0, 1'b0, 64'h0000_0000_DEAD_BEEF, 1);
        run_job(8'd6, 8, 0, 0, 1'b0, 64'h1234_5678_9ABC_DEF0, 0);
        run_job(8'd7, 0, 0, 0, 1'b0, 64'h1111_2222_3333_4444, 2);
        run_job(8'd8, 100, 0, 3, 1'b0, 64'h5555_6666_7777_8888, 0);
        run_job(8'd9, 100, 9, 9, 1'b0, 64'h0BAD_F00D_0000_0009, 1);
        run_job(8'd10, 20, 20, 0, 1'b0, 64'hCAFE_0000_0000_0014, 0);
        run_job(8'd11, 10, 0, 0, 1'b1, 64'h9999_0000_0000_0001, 1);

        // Backpressure: first result held, FIFO filled behind it
        sc_found = 0; sc_abort = 0; sc_stuck = 1'b0;
        push_job(8'd20, 3);
        wait_result(40);
        for (int k = 1; k <= 4; k++) begin
            push_job(ID_W'(20 + k), 3);
            chk("bp_level", level, k);
        end
        bus.job_id = 8'd25; bus.job_budget = 3; bus.job_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready_low", bus.job_ready, 1'b0);
            chk("bp_busy", busy, 1'b1);
            chk("bp_res_id", bus.res_id, 8'd20);
            chk("bp_res_valid", bus.res_valid, 1'b1);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("bp_no_bypass", bus.job_ready, 1'b0);
        @(negedge clk);
        chk("bp_pop_level", level, 3);
        chk("bp_ready_high", bus.job_ready, 1'b1);
        @(negedge clk);
        bus.job_valid = 1'b0;
        chk("bp_refill_level", level, 4);
        for (int k = 1; k <= 5; k++) begin
            wait_result(60);
            chk("bp_order_id", bus.res_id, ID_W'(20 + k));
            chk("bp_code", bus.res_code, 1);
            chk("bp_cycles", bus.res_cycles, 3);
            ack_result();
        end

        // Randomized jobs
        for (int n = 0; n < 30; n++) begin
            run_job(ID_W'($urandom), $urandom_range(0, 40), $urandom_range(0, 45),
                    $urandom_range(0, 45), ($urandom_range(0, 9) == 0),
                    {$urandom, $urandom}, $urandom_range(0, 3));
        end

        // Reset in the middle of RUN with another job queued
        sc_found = 0; sc_abort = 0; sc_stuck = 1'b0;
        push_job(8'd40, 1000);
        push_job(8'd41, 5);
        cnt = 0;
        while (!core_control[CTL_RUN] && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("mid_run", core_control[CTL_RUN], 1'b1);
        chk("mid_level", level, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_run", core_control[CTL_RUN], 1'b0);
        chk("mrst_control", core_control, 0);
        chk("mrst_level", level, 0);
        chk("mrst_ready", bus.job_ready, 1'b1);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_res_valid", bus.res_valid, 1'b0);
        chk("mrst_header", core_header, 0);
        chk("mrst_cycles", bus.res_cycles, 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.res_valid || busy) cnt++;
        end
        chk("mrst_quiet", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
